// File: rtl/ysyx_22050710_wbu.sv
// Write-back stage: MemOP extension, load alignment check, 2-entry skid buffer, retire counter.
// Latency 1 cycle from accept to o_valid; o_ready is registered and drops while both slots are full.
module ysyx_22050710_wbu #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic [XLEN-1:0]   i_mem_rdata,
  input  logic [2:0]        i_MemOP,
  input  logic              i_MemtoReg,
  input  logic              i_RegWr,
  input  logic [RIDX_W-1:0] i_rd,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_RegWr,
  output logic [RIDX_W-1:0] o_rd,
  output logic [XLEN-1:0]   o_wdata,
  output logic              o_misalign,
  output logic [63:0]       o_retired
);

  typedef struct packed {
    logic              regwr;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   wdata;
    logic              misalign;
  } ent_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t          state_q, state_d;
  ent_t            head_q, head_d, skid_q, skid_d, in_ent;
  logic            ready_q;
  logic [63:0]     retired_q, retired_d;
  logic [XLEN-1:0] ext;
  logic            mis;
  logic            accept, handoff;

  always_comb begin
    ext = '0;
    case (i_MemOP)
      3'b000:  ext = {{(XLEN-8){i_mem_rdata[7]}},   i_mem_rdata[7:0]};
      3'b001:  ext = {{(XLEN-8){1'b0}},             i_mem_rdata[7:0]};
      3'b010:  ext = {{(XLEN-16){i_mem_rdata[15]}}, i_mem_rdata[15:0]};
      3'b011:  ext = {{(XLEN-16){1'b0}},            i_mem_rdata[15:0]};
      3'b100:  ext = {{(XLEN-32){i_mem_rdata[31]}}, i_mem_rdata[31:0]};
      3'b101:  ext = {{(XLEN-32){1'b0}},            i_mem_rdata[31:0]};
      3'b110:  ext = i_mem_rdata;
      default: ext = '0;
    endcase
  end

  // Byte loads and the "no memory op" encoding never fault.
  assign mis = i_MemtoReg &
               (((i_MemOP[2:1] == 2'b01) & i_alu_result[0]) |
                ((i_MemOP[2:1] == 2'b10) & (|i_alu_result[1:0])) |
                ((i_MemOP == 3'b110) & (|i_alu_result[2:0])));

  always_comb begin
    in_ent.misalign = mis;
    in_ent.rd       = i_rd;
    in_ent.regwr    = i_RegWr & (i_rd != '0) & ~mis;
    in_ent.wdata    = mis ? '0 : (i_MemtoReg ? ext : i_alu_result);
  end

  assign accept  = i_valid & ready_q;
  assign handoff = (state_q != S_EMPTY) & i_ready;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    skid_d    = skid_q;
    retired_d = retired_q;
    case (state_q)
      S_EMPTY: if (accept) begin
        head_d  = in_ent;
        state_d = S_ONE;
      end
      S_ONE: begin
        if (accept && handoff) begin
          head_d = in_ent;
        end else if (accept) begin
          skid_d  = in_ent;
          state_d = S_TWO;
        end else if (handoff) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: if (handoff) begin
        head_d  = skid_q;
        state_d = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase
    if (handoff) retired_d = retired_q + 64'd1;
    // Flush wins over everything else this cycle, including the counter.
    if (i_flush) begin
      state_d   = S_EMPTY;
      head_d    = head_q;
      skid_d    = skid_q;
      retired_d = retired_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= S_EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      ready_q   <= 1'b1;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      ready_q   <= (state_d != S_TWO);
      retired_q <= retired_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = (state_q != S_EMPTY);
  assign o_RegWr    = head_q.regwr;
  assign o_rd       = head_q.rd;
  assign o_wdata    = head_q.wdata;
  assign o_misalign = head_q.misalign;
  assign o_retired  = retired_q;

endmodule
